// File: rtl/mac_seq_pkg.sv
// Shared types for the MAC job sequencer: FSM states,
// status codes and MNT field helpers.
package mac_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_CLEAR,
    S_START,
    S_RUN,
    S_STATUS
  } state_e;

  localparam logic [1:0] STS_OK      = 2'b00;
  localparam logic [1:0] STS_BAD_MNT = 2'b01;
  localparam logic [1:0] STS_TIMEOUT = 2'b10;

  localparam int MNT_W = 12;
  localparam int DIM_W = 4;

  function automatic logic [DIM_W-1:0] mnt_m(
    input logic [MNT_W-1:0] mnt
  );
    return mnt[11:8];
  endfunction

  function automatic logic [DIM_W-1:0] mnt_n(
    input logic [MNT_W-1:0] mnt
  );
    return mnt[7:4];
  endfunction

  function automatic logic [DIM_W-1:0] mnt_t(
    input logic [MNT_W-1:0] mnt
  );
    return mnt[3:0];
  endfunction

  function automatic logic dim_ok(
    input logic [DIM_W-1:0] d,
    input int unsigned      dim_max
  );
    return (d != '0) && (32'(d) <= dim_max);
  endfunction

  function automatic logic mnt_legal(
    input logic [MNT_W-1:0] mnt,
    input int unsigned      dim_max
  );
    return dim_ok(mnt_m(mnt), dim_max)
        && dim_ok(mnt_n(mnt), dim_max)
        && dim_ok(mnt_t(mnt), dim_max);
  endfunction

endpackage

// File: rtl/mac_job_sequencer_if.sv
// Host command/status, mac_top and output-BRAM signals of the
// sequencer. slave = sequencer view, master = host/mac_top view.
interface mac_job_sequencer_if #(
  parameter int OUT_AW  = 4,
  parameter int OUT_BW  = 128,
  parameter int JOB_IDW = 8
);
  logic               CMD_VALID;
  logic               CMD_READY;
  logic [11:0]        CMD_MNT;
  logic               STS_VALID;
  logic               STS_READY;
  logic [1:0]         STS_CODE;
  logic [JOB_IDW-1:0] STS_JOB_ID;
  logic [15:0]        STS_CYCLES;
  logic               BUSY;
  logic [11:0]        MAC_MNT;
  logic               MAC_START;
  logic               MAC_DONE;
  logic               MAC_EN_O;
  logic               MAC_RW_O;
  logic [OUT_AW-1:0]  MAC_ADDR_O;
  logic [OUT_BW-1:0]  MAC_WDATA_O;
  logic               EN_O;
  logic               RW_O;
  logic [OUT_AW-1:0]  ADDR_O;
  logic [OUT_BW-1:0]  WDATA_O;

  modport slave (
    input  CMD_VALID, CMD_MNT, STS_READY,
    input  MAC_DONE, MAC_EN_O, MAC_RW_O,
    input  MAC_ADDR_O, MAC_WDATA_O,
    output CMD_READY, STS_VALID, STS_CODE,
    output STS_JOB_ID, STS_CYCLES, BUSY,
    output MAC_MNT, MAC_START,
    output EN_O, RW_O, ADDR_O, WDATA_O
  );

  modport master (
    output CMD_VALID, CMD_MNT, STS_READY,
    output MAC_DONE, MAC_EN_O, MAC_RW_O,
    output MAC_ADDR_O, MAC_WDATA_O,
    input  CMD_READY, STS_VALID, STS_CODE,
    input  STS_JOB_ID, STS_CYCLES, BUSY,
    input  MAC_MNT, MAC_START,
    input  EN_O, RW_O, ADDR_O, WDATA_O
  );
endinterface

// File: rtl/mac_cmd_fifo.sv
// Synchronous command FIFO, DEPTH x W, show-ahead read port.
// Ports: clk, rst_n, push/wdata, pop/rdata, full, empty.
module mac_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wr_q] = wdata;
      wr_d        = wr_q + 1'b1;
    end
    if (pop) begin
      rd_d = rd_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign rdata = mem_q[rd_q];
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/mac_job_sequencer.sv
// Job sequencer for mac_top: FIFO of MNT jobs, BRAM clear, START/DONE,
// status report, output-BRAM port mux. Ports: CLK, RSTN, bus (slave).
// Optional cycle counter in STS_CYCLES when MJS_PERF_CNT_EN is defined.
module mac_job_sequencer
  import mac_seq_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int OUT_AW      = 4,
  parameter int OUT_ENTRY   = 16,
  parameter int OUT_BW      = 128,
  parameter int DIM_MAX     = 8,
  parameter int TIMEOUT_CYC = 4096,
  parameter int JOB_IDW     = 8
) (
  input logic                 CLK,
  input logic                 RSTN,
  mac_job_sequencer_if.slave  bus
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_e             state_q, state_d;
  logic [MNT_W-1:0]   mnt_q, mnt_d;
  logic [JOB_IDW-1:0] id_q, id_d;
  logic [JOB_IDW-1:0] nid_q, nid_d;
  logic [OUT_AW-1:0]  clr_q, clr_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic [1:0]         code_q, code_d;

  logic             push, pop;
  logic             full, empty;
  logic [MNT_W-1:0] fifo_rd;
  logic             legal, clr_last, tmo_hit;

  assign push     = bus.CMD_VALID && !full;
  assign pop      = (state_q == S_IDLE) && !empty;
  assign legal    = mnt_legal(mnt_q, DIM_MAX);
  assign clr_last = (clr_q == OUT_AW'(OUT_ENTRY - 1));
  assign tmo_hit  = (tmo_q == TW'(TIMEOUT_CYC - 1));

  mac_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (MNT_W)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RSTN),
    .push  (push),
    .wdata (bus.CMD_MNT),
    .pop   (pop),
    .rdata (fifo_rd),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (!empty) state_d = S_CHECK;
      S_CHECK:  state_d = legal ? S_CLEAR : S_STATUS;
      S_CLEAR:  if (clr_last) state_d = S_START;
      S_START:  state_d = S_RUN;
      S_RUN:    if (bus.MAC_DONE || tmo_hit) state_d = S_STATUS;
      S_STATUS: if (bus.STS_READY) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // tmo_q counts cycles since START so the abort lands exactly
  // TIMEOUT_CYC cycles after the START pulse.
  always_comb begin
    mnt_d  = mnt_q;
    id_d   = id_q;
    nid_d  = nid_q;
    clr_d  = clr_q;
    tmo_d  = tmo_q;
    code_d = code_q;
    if (pop) begin
      mnt_d = fifo_rd;
      id_d  = nid_q;
      nid_d = nid_q + 1'b1;
    end
    unique case (state_q)
      S_CHECK: if (!legal) code_d = STS_BAD_MNT;
      S_CLEAR: clr_d = clr_last ? '0 : clr_q + 1'b1;
      S_START: tmo_d = TW'(1);
      S_RUN: begin
        tmo_d = tmo_q + 1'b1;
        if (bus.MAC_DONE)  code_d = STS_OK;
        else if (tmo_hit)  code_d = STS_TIMEOUT;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      mnt_q  <= '0;
      id_q   <= '0;
      nid_q  <= '0;
      clr_q  <= '0;
      tmo_q  <= '0;
      code_q <= '0;
    end else begin
      mnt_q  <= mnt_d;
      id_q   <= id_d;
      nid_q  <= nid_d;
      clr_q  <= clr_d;
      tmo_q  <= tmo_d;
      code_q <= code_d;
    end
  end

`ifdef MJS_PERF_CNT_EN
  logic [15:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (state_q == S_START) begin
      cyc_d = '0;
    end else if (state_q == S_RUN && cyc_q != 16'hFFFF) begin
      cyc_d = cyc_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end
`endif

  always_comb begin
    bus.CMD_READY  = !full;
    bus.BUSY       = (state_q != S_IDLE) || !empty;
    bus.MAC_START  = (state_q == S_START);
    bus.MAC_MNT    = mnt_q;
    bus.STS_VALID  = (state_q == S_STATUS);
    bus.STS_CODE   = bus.STS_VALID ? code_q : '0;
    bus.STS_JOB_ID = bus.STS_VALID ? id_q : '0;
`ifdef MJS_PERF_CNT_EN
    bus.STS_CYCLES = bus.STS_VALID ? cyc_q : '0;
`else
    bus.STS_CYCLES = '0;
`endif
    if (state_q == S_CLEAR) begin
      bus.EN_O    = 1'b1;
      bus.RW_O    = 1'b1;
      bus.ADDR_O  = clr_q;
      bus.WDATA_O = {OUT_BW{1'b0}};
    end else begin
      bus.EN_O    = bus.MAC_EN_O;
      bus.RW_O    = bus.MAC_RW_O;
      bus.ADDR_O  = bus.MAC_ADDR_O;
      bus.WDATA_O = bus.MAC_WDATA_O;
    end
  end

endmodule

// File: tb/tb_mac_job_sequencer.sv
// Directed bench for mac_job_sequencer with a mac_top stub
// and an output-BRAM model fed from the muxed port.
module tb_mac_job_sequencer;
  logic clk;
  logic rstn;

  mac_job_sequencer_if #(
    .OUT_AW(4), .OUT_BW(128), .JOB_IDW(8)
  ) bus ();

  mac_job_sequencer #(
    .FIFO_DEPTH(4), .OUT_AW(4), .OUT_ENTRY(16),
    .OUT_BW(128), .DIM_MAX(8), .TIMEOUT_CYC(64),
    .JOB_IDW(8)
  ) dut (
    .CLK  (clk),
    .RSTN (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [127:0] bram [16];
  logic [3:0]   wr_addr [256];
  int cyc = 0, wr_cnt = 0, start_cnt = 0, sts_cnt = 0;
  int start_cyc = 0, acc_cyc = 0, sts_cyc = 0;
  logic sts_prev = 1'b0;

  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 16; i++) bram[i] = 128'hDEAD;
    end
    if (bus.EN_O && bus.RW_O) begin
      bram[bus.ADDR_O] = bus.WDATA_O;
      wr_addr[wr_cnt & 255] = bus.ADDR_O;
      wr_cnt++;
    end
    if (bus.CMD_VALID && bus.CMD_READY && rstn) acc_cyc = cyc;
    if (bus.MAC_START) begin
      start_cnt++;
      start_cyc = cyc;
    end
    if (bus.STS_VALID && !sts_prev) begin
      sts_cyc = cyc;
      sts_cnt++;
    end
    sts_prev = bus.STS_VALID;
    cyc++;
  end

  // mac_top stub: 3 cycles after START write MNT to addr 0,
  // DONE one cycle later. Disabled stub never raises DONE.
  logic stub_en;
  int   stub_cnt;
  initial begin
    stub_cnt = 0;
    bus.MAC_EN_O = 0; bus.MAC_RW_O = 0; bus.MAC_DONE = 0;
    bus.MAC_ADDR_O = '0; bus.MAC_WDATA_O = '0;
    forever begin
      @(posedge clk); #1;
      bus.MAC_EN_O = 0; bus.MAC_RW_O = 0; bus.MAC_DONE = 0;
      bus.MAC_ADDR_O = '0; bus.MAC_WDATA_O = '0;
      if (!rstn) stub_cnt = 0;
      else if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 1) begin
          bus.MAC_EN_O = 1; bus.MAC_RW_O = 1;
          bus.MAC_WDATA_O = {116'b0, bus.MAC_MNT};
        end
        if (stub_cnt == 0) bus.MAC_DONE = 1;
      end else if (bus.MAC_START && stub_en) stub_cnt = 4;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [11:0] mnt);
    int n = 0;
    bus.CMD_VALID = 1; bus.CMD_MNT = mnt;
    while (!bus.CMD_READY && n < 50) begin tick(1); n++; end
    tick(1);
    bus.CMD_VALID = 0;
  endtask

  task automatic wait_sts(input string tag, input int bound);
    int n = 0;
    while (!bus.STS_VALID && n < bound) begin tick(1); n++; end
    chk(tag, bus.STS_VALID, 1);
  endtask

  task automatic do_reset();
    rstn = 0;
    tick(2);
    rstn = 1;
    tick(1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, bus.CMD_READY, 1);
    chk({tag, "_busy"},  bus.BUSY, 0);
    chk({tag, "_sv"},    bus.STS_VALID, 0);
    chk({tag, "_start"}, bus.MAC_START, 0);
    chk({tag, "_en"},    bus.EN_O, 0);
  endtask

  logic [11:0] jobs [5];
  int b_wr, b_st, b_sts, ok, n;

  initial begin
    jobs[0] = 12'h444; jobs[1] = 12'h337; jobs[2] = 12'h374;
    jobs[3] = 12'h376; jobs[4] = 12'h634;
    rstn = 1; stub_en = 1;
    bus.CMD_VALID = 0; bus.CMD_MNT = '0; bus.STS_READY = 0;
    #3 rstn = 0;
    tick(2);
    chk_idle("rst");
    chk("rst_code", bus.STS_CODE, 0);
    chk("rst_id", bus.STS_JOB_ID, 0);
    chk("rst_cyc", bus.STS_CYCLES, 0);
    chk("rst_mnt", bus.MAC_MNT, 0);
    rstn = 1;
    tick(2);

    // single legal job
    bus.STS_READY = 1;
    b_wr = wr_cnt; b_st = start_cnt;
    push(12'h444);
    wait_sts("t1_sts", 60);
    chk("t1_code", bus.STS_CODE, 2'b00);
    chk("t1_id", bus.STS_JOB_ID, 0);
    chk("t1_cycles", bus.STS_CYCLES, 0);
    tick(1);
    // START is high right after accept edge + 18,
    // so the first edge that samples it is accept + 19
    chk("t1_latency", start_cyc - acc_cyc, 19);
    chk("t1_starts", start_cnt - b_st, 1);
    chk("t1_writes", wr_cnt - b_wr, 17);
    ok = 1;
    for (int i = 0; i < 16; i++)
      if (wr_addr[(b_wr + i) & 255] != 4'(i)) ok = 0;
    chk("t1_clr_seq", ok, 1);
    ok = 1;
    if (bram[0] !== 128'h444) ok = 0;
    for (int i = 1; i < 16; i++) if (bram[i] !== '0) ok = 0;
    chk("t1_bram", ok, 1);
    chk("t1_busy", bus.BUSY, 0);

    // five jobs back to back; one is popped while pushing,
    // so the FIFO fills after the fifth accept
    do_reset();
    b_st = start_cnt;
    bus.CMD_VALID = 1;
    for (int i = 0; i < 5; i++) begin
      bus.CMD_MNT = jobs[i];
      chk($sformatf("t2_ready%0d", i), bus.CMD_READY, 1);
      tick(1);
    end
    bus.CMD_VALID = 0;
    chk("t2_full", bus.CMD_READY, 0);
    for (int i = 0; i < 5; i++) begin
      wait_sts($sformatf("t2_sts%0d", i), 80);
      chk($sformatf("t2_code%0d", i), bus.STS_CODE, 0);
      chk($sformatf("t2_id%0d", i), bus.STS_JOB_ID, i);
      chk($sformatf("t2_order%0d", i), bram[0], {116'b0, jobs[i]});
      tick(1);
    end
    chk("t2_starts", start_cnt - b_st, 5);

    // illegal MNT words
    do_reset();
    b_st = start_cnt; b_wr = wr_cnt;
    push(12'h904);
    push(12'h044);
    wait_sts("t3_sts0", 10);
    chk("t3_code0", bus.STS_CODE, 2'b01);
    chk("t3_id0", bus.STS_JOB_ID, 0);
    tick(1);
    wait_sts("t3_sts1", 10);
    chk("t3_code1", bus.STS_CODE, 2'b01);
    chk("t3_id1", bus.STS_JOB_ID, 1);
    tick(1);
    chk("t3_starts", start_cnt - b_st, 0);
    chk("t3_writes", wr_cnt - b_wr, 0);

    // timeout: DONE never rises
    do_reset();
    stub_en = 0;
    b_wr = wr_cnt;
    push(12'h444);
    wait_sts("t4_sts", 120);
    chk("t4_code", bus.STS_CODE, 2'b10);
    chk("t4_id", bus.STS_JOB_ID, 0);
    tick(1);
    chk("t4_delay", sts_cyc - start_cyc, 64);
    chk("t4_writes", wr_cnt - b_wr, 16);
    stub_en = 1;

    // status back-pressure with a queued job
    do_reset();
    bus.STS_READY = 0;
    b_st = start_cnt;
    push(12'h444);
    push(12'h337);
    wait_sts("t5_sts0", 60);
    tick(20);
    chk("t5_held", bus.STS_VALID, 1);
    chk("t5_hold_id", bus.STS_JOB_ID, 0);
    chk("t5_no_start", start_cnt - b_st, 1);
    chk("t5_busy", bus.BUSY, 1);
    bus.STS_READY = 1;
    tick(1);
    wait_sts("t5_sts1", 60);
    chk("t5_id1", bus.STS_JOB_ID, 1);
    chk("t5_starts", start_cnt - b_st, 2);
    tick(1);

    // reset while clearing, with a second job queued
    do_reset();
    b_st = start_cnt; b_sts = sts_cnt;
    push(12'h444);
    push(12'h337);
    tick(5);
    chk("t6_in_clear", bus.EN_O, 1);
    rstn = 0;
    tick(1);
    chk_idle("t6_rst");
    rstn = 1;
    tick(30);
    chk("t6_starts", start_cnt - b_st, 0);
    chk("t6_no_sts", sts_cnt - b_sts, 0);
    chk("t6_busy", bus.BUSY, 0);

    // reset while running
    b_st = start_cnt; b_sts = sts_cnt;
    push(12'h444);
    n = 0;
    while (start_cnt == b_st && n < 40) begin tick(1); n++; end
    chk("t7_started", start_cnt - b_st, 1);
    tick(1);
    rstn = 0;
    tick(1);
    chk_idle("t7_rst");
    rstn = 1;
    tick(30);
    chk("t7_no_sts", sts_cnt - b_sts, 0);
    chk("t7_busy", bus.BUSY, 0);
    chk("t7_starts", start_cnt - b_st, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
